// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg -- shared types and default parameters for the multi-port
// register file.
//   state_e      : sweep FSM states (CLEAR, READY)
//   *_DEF        : default parameter values used by regfile_mp and its sub-module
package regfile_mp_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_RD_DEF   = 2;
  localparam int ZERO_REG_DEF = 31;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_mp_clr.sv
// regfile_mp_clr -- clear-sweep FSM and sweep index counter.
// After reset (or an accepted clear request) it walks clr_idx over every
// register, one per cycle, then reports READY.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   synchronous active-low reset, restarts the sweep at 0
//   clr_req  in   clear request, honoured only in READY
//   ready    out  1 when in READY
//   clr_we   out  1 when the sweep zeroes register clr_idx this cycle
//   clr_idx  out  register being zeroed
module regfile_mp_clr
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLEAR: begin
        // clr_req is ignored here; the sweep always runs to completion.
        idx_d = idx_q + 1'b1;
        if (idx_q == {ADDR_W{1'b1}}) begin
          state_d = READY;
          idx_d   = '0;
        end
      end
      READY: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  assign ready   = (state_q == READY);
  assign clr_we  = (state_q == CLEAR);
  assign clr_idx = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-read-port register file with a hardwired zero register
// and a cycle-by-cycle clear sweep instead of a storage reset.
// Optional feature: define REGFILE_MP_BYPASS_EN to forward an accepted write
// to any read port addressing the same register in the same cycle.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   synchronous active-low reset (starts a clear sweep)
//   wr_en    in   write request
//   wr_addr  in   [ADDR_W]          write index
//   wr_data  in   [DATA_W]          write data
//   clr_req  in   request to zero the whole file
//   rd_addr  in   [NUM_RD][ADDR_W]  read index per port
//   rd_data  out  [NUM_RD][DATA_W]  combinational read data per port
//   ready    out  1 when the file accepts writes
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic                           clr_req,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic                           ready
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZR    = ADDR_W'(ZERO_REG);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_ok;

  logic [DATA_W-1:0] mem_q [DEPTH];

  regfile_mp_clr #(.ADDR_W(ADDR_W)) u_clr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_req (clr_req),
    .ready   (ready),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  // Clear has priority over a same-cycle write; a reset edge is never a write.
  assign wr_ok = ready && reset_n && wr_en && !clr_req && (wr_addr != ZR);

  // No storage reset: the sweep is the only thing that zeroes registers.
  always_ff @(posedge clk) begin
    if (clr_we && reset_n) begin
      mem_q[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [DATA_W-1:0] rd_v;
    always_comb begin
      rd_v = mem_q[rd_addr[p]];
`ifdef REGFILE_MP_BYPASS_EN
      if (wr_ok && (rd_addr[p] == wr_addr)) rd_v = wr_data;
`endif
      // Zero register and clearing mode override everything, bypass included.
      if (!ready || (rd_addr[p] == ZR)) rd_v = '0;
    end
    assign rd_data[p] = rd_v;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int ZR     = 31;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          reset_n = 1'b1;
  logic                          wr_en   = 1'b0;
  logic [ADDR_W-1:0]             wr_addr = '0;
  logic [DATA_W-1:0]             wr_data = '0;
  logic                          clr_req = 1'b0;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr = '0;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic                          ready;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZR)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clr_req (clr_req),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .ready   (ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: register contents plus a countdown of remaining
  // clearing cycles (0 = file usable).
  logic [DATA_W-1:0] mdl [DEPTH];
  int clr_left = 0;
  bit started  = 1'b0;

  logic                          obs_ready;
  logic [NUM_RD-1:0][DATA_W-1:0] obs_rd;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_rd(input int a);
    if (clr_left != 0 || a == ZR) return '0;
    if (BYP && wr_en && !clr_req && int'(wr_addr) == a) return wr_data;
    return mdl[a];
  endfunction

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  // Entered just after a falling edge with inputs already applied.
  task automatic cycle();
    #1;
    obs_ready = ready;
    obs_rd    = rd_data;
    if (started) begin
      chk("ready", DATA_W'(ready), DATA_W'(clr_left == 0));
      for (int p = 0; p < NUM_RD; p++)
        chk($sformatf("rd%0d_addr%0d", p, rd_addr[p]), rd_data[p], exp_rd(int'(rd_addr[p])));
    end
    @(posedge clk);
    if (!reset_n) begin
      clr_left = DEPTH;
      zero_model();
      started = 1'b1;
    end else if (started) begin
      if (clr_left > 0) clr_left--;
      else if (clr_req) begin
        clr_left = DEPTH;
        zero_model();
      end else if (wr_en && int'(wr_addr) != ZR) mdl[wr_addr] = wr_data;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic rn, input logic we, input int wa, input logic [DATA_W-1:0] wd,
                       input logic cr, input int ra0, input int ra1);
    reset_n = rn;
    wr_en   = we;
    wr_addr = ADDR_W'(wa);
    wr_data = wd;
    clr_req = cr;
    for (int p = 0; p < NUM_RD; p++) rd_addr[p] = ADDR_W'((p == 0) ? ra0 : ra1);
    cycle();
  endtask

  // Idles until ready is seen high; n = number of cycles it was low.
  task automatic count_low(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b0, 0, '0, 1'b0, 5, 3);
      if (obs_ready === 1'b1) break;
      n++;
    end
  endtask

  initial begin
    int n;
    logic [DATA_W-1:0] v;
    int wa, ra0, ra1;
    logic rn, cr, we;

    @(negedge clk);

    // Reset: ready low for exactly DEPTH cycles, then all reads zero.
    drive(1'b0, 1'b0, 0, '0, 1'b0, 0, 0);
    count_low(n);
    chk("reset_low_cycles", DATA_W'(n), DATA_W'(DEPTH));
    chk("reset_ready_after", DATA_W'(obs_ready), DATA_W'(1));
    for (int p = 0; p < NUM_RD; p++) chk("reset_rd_zero", obs_rd[p], '0);

    // Write X5, read it on every port next cycle.
    v = DATA_W'(64'hDEADBEEF_00000001);
    drive(1'b1, 1'b1, 5, v, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, '0, 1'b0, 5, 5);
    for (int p = 0; p < NUM_RD; p++) chk("x5_multiport", obs_rd[p], v);

    // Writes to the zero register never show.
    drive(1'b1, 1'b1, ZR, '1, 1'b0, ZR, ZR);
    chk("xzr_same_cycle", obs_rd[0], '0);
    drive(1'b1, 1'b0, 0, '0, 1'b0, ZR, ZR);
    chk("xzr_next_cycle", obs_rd[0], '0);

    // Same-cycle read of the register being written.
    v = DATA_W'(64'h1234);
    drive(1'b1, 1'b1, 7, v, 1'b0, 7, 7);
    chk("x7_same_cycle", obs_rd[0], BYP ? v : '0);
    drive(1'b1, 1'b0, 0, '0, 1'b0, 7, 5);
    chk("x7_next_cycle", obs_rd[0], v);

    // Clear wins over a simultaneous write.
    drive(1'b1, 1'b1, 3, DATA_W'(64'h55), 1'b0, 3, 3);
    drive(1'b1, 1'b1, 3, DATA_W'(64'hAA), 1'b1, 3, 3);
    count_low(n);
    chk("clr_low_cycles", DATA_W'(n), DATA_W'(DEPTH));
    drive(1'b1, 1'b0, 0, '0, 1'b0, 3, 7);
    chk("x3_after_clr", obs_rd[0], '0);
    chk("x7_after_clr", obs_rd[1], '0);

    // Mid-sweep: clr_req ignored, reset at index 10 restarts the sweep.
    drive(1'b1, 1'b1, 9, DATA_W'(64'h99), 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, '0, 1'b1, 0, 0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 9, '1, (i == 4), 9, 9);
    drive(1'b0, 1'b0, 0, '0, 1'b0, 9, 9);
    count_low(n);
    chk("midsweep_reset_low", DATA_W'(n), DATA_W'(DEPTH));
    drive(1'b1, 1'b0, 0, '0, 1'b0, 9, 9);
    chk("x9_after_reset", obs_rd[0], '0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rn  = ($urandom_range(149) != 0);
      cr  = ($urandom_range(59) == 0);
      we  = rn ? 1'($urandom_range(1)) : 1'b0;
      wa  = int'($urandom_range(DEPTH - 1));
      v   = DATA_W'({$urandom, $urandom});
      ra0 = ($urandom_range(3) == 0) ? wa : int'($urandom_range(DEPTH - 1));
      ra1 = ($urandom_range(3) == 0) ? ra0 : int'($urandom_range(DEPTH - 1));
      drive(rn, we, wa, v, cr, ra0, ra1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..8).
REQ-004 SHALL have parameter ZERO_REG, default 31, index hardwired to zero (XZR).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port wr_en  input  1  write request for the current cycle.
REQ-008 SHALL have port wr_addr  input  ADDR_W  write register index.
REQ-009 SHALL have port wr_data  input  DATA_W  write data.
REQ-010 SHALL have port clr_req  input  1  request to zero the whole file.
REQ-011 SHALL have port rd_addr  input  NUM_RD x ADDR_W  read index per port.
REQ-012 SHALL have port rd_data  output  NUM_RD x DATA_W  read data per port.
REQ-013 SHALL have port ready  output  1  high when file is in READY and accepts writes.

Function
REQ-014 SHALL implement FSM states CLEAR and READY only.
REQ-015 SHALL, in CLEAR, write zero to register clr_idx each cycle, clr_idx counting 0..DEPTH-1, then enter READY the cycle after clr_idx = DEPTH-1 (DEPTH cycles total).
REQ-016 SHALL drive ready = 1 exactly when state is READY.
REQ-017 SHALL, in READY, write wr_data to wr_addr at the rising edge when wr_en = 1, clr_req = 0 and wr_addr != ZERO_REG.
REQ-018 SHALL silently drop writes to ZERO_REG and any write while in CLEAR.
REQ-019 SHALL, in READY with clr_req = 1, enter CLEAR next cycle with clr_idx = 0; a simultaneous wr_en is dropped (clear has priority).
REQ-020 SHALL ignore clr_req while in CLEAR (no sweep restart).
REQ-021 SHALL produce rd_data combinationally (zero-cycle latency) from rd_addr and current register contents.
REQ-022 SHALL return zero on any port whose rd_addr = ZERO_REG, regardless of mode.
REQ-023 SHALL return zero on all read ports while in CLEAR.
REQ-024 SHALL serve any number of ports reading the same index with identical data.

Reset
REQ-025 SHALL, with reset_n = 0 at a rising edge, enter CLEAR with clr_idx = 0, ready = 0; rd_data = 0 on all ports the following cycle.
REQ-026 SHALL restart the sweep at index 0 when reset occurs mid-sweep or mid-operation.
REQ-027 SHALL NOT reset register storage directly; zeroing is done only by the sweep.

Configuration
REQ-028 SHALL support macro REGFILE_MP_BYPASS_EN: when defined, a read port whose rd_addr equals wr_addr during an accepted write (REQ-017) returns wr_data in that same cycle; when undefined it returns the pre-write value and the new value appears the next cycle.
REQ-029 SHALL keep REQ-022 (zero register) priority over bypass in both builds.

Structure
REQ-030 SHALL place the FSM state enum (CLEAR, READY) and default parameter constants in shared package regfile_mp_pkg.
REQ-031 SHALL implement sweep FSM and clr_idx counter in one sub-module regfile_mp_clr; storage, write decode and read muxes stay in regfile_mp.

Verification
REQ-032 SHALL cover: reset_n low 1 cycle -> ready = 0 for exactly 32 cycles (defaults), then ready = 1; all rd_data = 0.
REQ-033 SHALL cover: write X5 = 0xDEADBEEF_00000001, next cycle rd_addr[0] = 5, rd_addr[1] = 5 -> both ports read 0xDEADBEEF_00000001.
REQ-034 SHALL cover: write X31 = 0xFFFF_FFFF_FFFF_FFFF -> reading X31 returns 0 in same and next cycle.
REQ-035 SHALL cover: write X7 = 0x1234 with rd_addr[0] = 7 same cycle -> 0x1234 with REGFILE_MP_BYPASS_EN, prior value (0) without.
REQ-036 SHALL cover: clr_req with wr_en to X3 = 0xAA same cycle -> write dropped, ready low 32 cycles, X3 reads 0 after.
REQ-037 SHALL cover: reset_n low at sweep index 10 -> sweep restarts at 0, ready rises 32 cycles after reset release; NUM_RD = 4, DATA_W = 32 build passes the same tests.
